// File: rtl/elevator_queue_ctrl_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package    : elevator_pkg                                              |
// | Description: Shared constants, FSM state type and queue slot helper    |
// |              for the elevator queue controller.                        |
// | Revision   : 1.0 - initial release                                     |
// +------------------------------------------------------------------------+
package elevator_pkg;

  localparam int LEVELS          = 4;
  localparam int LVL_W           = 2;
  localparam int DEPTH           = 4;
  localparam int TAIL_W          = 3;
  localparam int MOVE_CYCLES_DEF = 8;
  localparam int DOOR_CYCLES_DEF = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVING    = 2'd1,
    DOOR_OPEN = 2'd2
  } state_t;

  // Entry i of a packed queue; entry 0 (the head) sits in the low bits.
  function automatic logic [LVL_W-1:0] get_slot(input logic [DEPTH*LVL_W-1:0] q,
                                                input int unsigned            i);
    return q[i*LVL_W +: LVL_W];
  endfunction

endpackage
`default_nettype wire

// File: rtl/elevator_queue_ctrl_add.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module     : next_queue_add_logic                                      |
// | Description: Append stage. Writes new_lvl into slot tail_in when       |
// |              add_new_lvl is set and a slot is free; bumps the tail.    |
// | Ports      : queue_in/tail_in   - queue state to append to             |
// |              add_new_lvl/new_lvl - append request and level            |
// |              queue_out/tail_out - queue state after the append         |
// | Revision   : 1.0 - initial release                                     |
// +------------------------------------------------------------------------+
module next_queue_add_logic #(
  parameter int DEPTH  = elevator_pkg::DEPTH,
  parameter int LVL_W  = elevator_pkg::LVL_W,
  parameter int TAIL_W = elevator_pkg::TAIL_W
) (
  input  logic [DEPTH*LVL_W-1:0] queue_in,
  input  logic [TAIL_W-1:0]      tail_in,
  input  logic                   add_new_lvl,
  input  logic [LVL_W-1:0]       new_lvl,
  output logic [DEPTH*LVL_W-1:0] queue_out,
  output logic [TAIL_W-1:0]      tail_out
);
  import elevator_pkg::*;

  logic w_room;

  assign w_room = (tail_in < TAIL_W'(DEPTH));

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    assign queue_out[gi*LVL_W +: LVL_W] =
        (add_new_lvl && (tail_in == TAIL_W'(gi))) ? new_lvl
                                                  : queue_in[gi*LVL_W +: LVL_W];
  end

  assign tail_out = (add_new_lvl && w_room) ? tail_in + TAIL_W'(1) : tail_in;

endmodule
`default_nettype wire

// File: rtl/elevator_queue_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module     : elevator_queue_ctrl                                       |
// | Description: Owns the elevator request queue and the car motion/door   |
// |              sequencing (IDLE -> MOVING -> DOOR_OPEN).                 |
// | Ports      : clk, rst_n         - clock, async active-low reset        |
// |              press_valid/lvl    - button press input                   |
// |              queue, tail        - request queue (entry 0 = head)       |
// |              cur_lvl            - floor the car is at / last passed    |
// |              moving, dir_up     - motion status and direction          |
// |              door_open          - door status                          |
// |              dropped            - one-cycle pulse on a rejected press  |
// | Revision   : 1.0 - initial release                                     |
// +------------------------------------------------------------------------+
module elevator_queue_ctrl #(
  parameter int LEVELS      = elevator_pkg::LEVELS,
  parameter int LVL_W       = elevator_pkg::LVL_W,
  parameter int DEPTH       = elevator_pkg::DEPTH,
  parameter int TAIL_W      = elevator_pkg::TAIL_W,
  parameter int MOVE_CYCLES = elevator_pkg::MOVE_CYCLES_DEF,
  parameter int DOOR_CYCLES = elevator_pkg::DOOR_CYCLES_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   press_valid,
  input  logic [LVL_W-1:0]       press_lvl,
  output logic [DEPTH*LVL_W-1:0] queue,
  output logic [TAIL_W-1:0]      tail,
  output logic [LVL_W-1:0]       cur_lvl,
  output logic                   moving,
  output logic                   dir_up,
  output logic                   door_open,
  output logic                   dropped
);
  import elevator_pkg::*;

  localparam int c_MOVE_W = (MOVE_CYCLES > 2) ? $clog2(MOVE_CYCLES) : 1;
  localparam int c_DOOR_W = $clog2(DOOR_CYCLES + 1);

  localparam logic [c_MOVE_W-1:0] c_MOVE_LOAD   = c_MOVE_W'(MOVE_CYCLES - 1);
  localparam logic [c_DOOR_W-1:0] c_DOOR_LOAD   = c_DOOR_W'(DOOR_CYCLES - 1);
  localparam logic [c_DOOR_W-1:0] c_DOOR_RELOAD = c_DOOR_W'(DOOR_CYCLES);

  state_t                   r_state, w_state_nxt;
  logic [DEPTH*LVL_W-1:0]   r_queue;
  logic [TAIL_W-1:0]        r_tail;
  logic [LVL_W-1:0]         r_cur_lvl, w_cur_lvl_nxt;
  logic [c_MOVE_W-1:0]      r_move_cnt, w_move_cnt_nxt;
  logic [c_DOOR_W-1:0]      r_door_cnt, w_door_cnt_nxt;
  logic                     r_moving, r_dir_up, r_door_open, r_dropped;

  logic [LVL_W-1:0]         w_head, w_step_lvl;
  logic                     w_step_tick, w_pop;
  logic [DEPTH*LVL_W-1:0]   w_pop_queue, w_add_queue;
  logic [TAIL_W-1:0]        w_pop_tail, w_add_tail;
  logic [DEPTH-1:0]         w_dup_hit;
  logic                     w_lvl_ok, w_press, w_at_floor, w_dup, w_dup_rej, w_full_rej, w_add;

  // Presses naming a floor that does not exist are ignored outright.
  if (LEVELS < (1 << LVL_W)) begin : g_range_chk
    assign w_lvl_ok = (int'(press_lvl) < LEVELS);
  end else begin : g_no_range_chk
    assign w_lvl_ok = 1'b1;
  end

  assign w_press = press_valid && w_lvl_ok;
  assign w_head  = get_slot(r_queue, 0);

  // One floor toward the head; holding still if already there keeps the
  // car inside the floor range even for a degenerate queue.
  always_comb begin
    w_step_lvl = r_cur_lvl;
    if (w_head > r_cur_lvl)      w_step_lvl = r_cur_lvl + LVL_W'(1);
    else if (w_head < r_cur_lvl) w_step_lvl = r_cur_lvl - LVL_W'(1);
  end

  assign w_step_tick = (r_state == MOVING) && (r_move_cnt == '0);
  assign w_pop       = w_step_tick && (w_step_lvl == w_head) && (r_tail != '0);

  // Pop happens ahead of the append so a same-cycle press lands at tail-1.
  assign w_pop_queue = w_pop ? {{LVL_W{1'b0}}, r_queue[DEPTH*LVL_W-1:LVL_W]} : r_queue;
  assign w_pop_tail  = w_pop ? r_tail - TAIL_W'(1) : r_tail;

  // Duplicates are judged against the queue as it stood before the pop, so
  // a press for the floor being arrived at is not re-queued.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_dup
    assign w_dup_hit[gi] = (r_tail > TAIL_W'(gi)) && (get_slot(r_queue, gi) == press_lvl);
  end

  assign w_at_floor = w_press && (press_lvl == r_cur_lvl) && (r_state != MOVING);
  assign w_dup      = |w_dup_hit;
  assign w_dup_rej  = w_press && !w_at_floor && w_dup;
  assign w_full_rej = w_press && !w_at_floor && !w_dup && (w_pop_tail == TAIL_W'(DEPTH));
  assign w_add      = w_press && !w_at_floor && !w_dup && !w_full_rej;

  next_queue_add_logic #(
    .DEPTH  (DEPTH),
    .LVL_W  (LVL_W),
    .TAIL_W (TAIL_W)
  ) u_add (
    .queue_in    (w_pop_queue),
    .tail_in     (w_pop_tail),
    .add_new_lvl (w_add),
    .new_lvl     (press_lvl),
    .queue_out   (w_add_queue),
    .tail_out    (w_add_tail)
  );

  always_comb begin
    w_state_nxt    = r_state;
    w_cur_lvl_nxt  = r_cur_lvl;
    w_move_cnt_nxt = r_move_cnt;
    w_door_cnt_nxt = r_door_cnt;
    case (r_state)
      IDLE: begin
        if (w_at_floor) begin
          w_state_nxt    = DOOR_OPEN;
          w_door_cnt_nxt = c_DOOR_LOAD;
        end else if (r_tail != '0) begin
          w_state_nxt    = MOVING;
          w_move_cnt_nxt = c_MOVE_LOAD;
        end
      end
      MOVING: begin
        if (r_move_cnt == '0) begin
          w_cur_lvl_nxt  = w_step_lvl;
          w_move_cnt_nxt = c_MOVE_LOAD;
          if (w_pop) begin
            w_state_nxt    = DOOR_OPEN;
            w_door_cnt_nxt = c_DOOR_LOAD;
          end
        end else begin
          w_move_cnt_nxt = r_move_cnt - c_MOVE_W'(1);
        end
      end
      DOOR_OPEN: begin
        if (w_at_floor) begin
          w_door_cnt_nxt = c_DOOR_RELOAD;
        end else if (r_door_cnt == '0) begin
          if (r_tail != '0) begin
            w_state_nxt    = MOVING;
            w_move_cnt_nxt = c_MOVE_LOAD;
          end else begin
            w_state_nxt = IDLE;
          end
        end else begin
          w_door_cnt_nxt = r_door_cnt - c_DOOR_W'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_queue     <= '0;
      r_tail      <= '0;
      r_cur_lvl   <= '0;
      r_move_cnt  <= '0;
      r_door_cnt  <= '0;
      r_moving    <= 1'b0;
      r_dir_up    <= 1'b0;
      r_door_open <= 1'b0;
      r_dropped   <= 1'b0;
    end else begin
      r_queue     <= w_add_queue;
      r_tail      <= w_add_tail;
      r_cur_lvl   <= w_cur_lvl_nxt;
      r_move_cnt  <= w_move_cnt_nxt;
      r_door_cnt  <= w_door_cnt_nxt;
      r_moving    <= (w_state_nxt == MOVING);
      r_door_open <= (w_state_nxt == DOOR_OPEN);
      r_dir_up    <= (w_state_nxt == MOVING) && (get_slot(w_add_queue, 0) > w_cur_lvl_nxt);
      r_dropped   <= w_dup_rej || w_full_rej;
    end
  end

  assign queue     = r_queue;
  assign tail      = r_tail;
  assign cur_lvl   = r_cur_lvl;
  assign moving    = r_moving;
  assign dir_up    = r_dir_up;
  assign door_open = r_door_open;
  assign dropped   = r_dropped;

endmodule
`default_nettype wire

// File: tb/tb_elevator_queue_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module     : tb_elevator_queue_ctrl                                    |
// | Description: Scoreboard bench for elevator_queue_ctrl. A timeline      |
// |              model predicts outputs per edge; a negedge monitor        |
// |              compares them against the design.                         |
// | Revision   : 1.0 - initial release                                     |
// +------------------------------------------------------------------------+
module tb_elevator_queue_ctrl;

  localparam int LVL_W       = 2;
  localparam int DEPTH       = 4;
  localparam int TAIL_W      = 3;
  localparam int MOVE_CYCLES = 8;
  localparam int DOOR_CYCLES = 16;

  localparam int MP_IDLE = 0;
  localparam int MP_MOVE = 1;
  localparam int MP_DOOR = 2;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   press_valid = 1'b0;
  logic [LVL_W-1:0]       press_lvl = '0;
  logic [DEPTH*LVL_W-1:0] queue;
  logic [TAIL_W-1:0]      tail;
  logic [LVL_W-1:0]       cur_lvl;
  logic                   moving, dir_up, door_open, dropped;

  elevator_queue_ctrl #(
    .LEVELS      (4),
    .LVL_W       (LVL_W),
    .DEPTH       (DEPTH),
    .TAIL_W      (TAIL_W),
    .MOVE_CYCLES (MOVE_CYCLES),
    .DOOR_CYCLES (DOOR_CYCLES)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .press_valid (press_valid),
    .press_lvl   (press_lvl),
    .queue       (queue),
    .tail        (tail),
    .cur_lvl     (cur_lvl),
    .moving      (moving),
    .dir_up      (dir_up),
    .door_open   (door_open),
    .dropped     (dropped)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DEPTH*LVL_W-1:0] queue;
    logic [TAIL_W-1:0]      tail;
    logic [LVL_W-1:0]       cur_lvl;
    logic                   moving;
    logic                   dir_up;
    logic                   door_open;
    logic                   dropped;
  } obs_t;

  obs_t exp_q[$];
  obs_t mon_e;
  int   errors = 0;
  int   checks = 0;

  // Reference model: requests as a plain list, time as absolute edge numbers.
  int m_q[$];
  int m_lvl, m_phase, m_now, m_step_at, m_close_at;

  task automatic model_reset();
    m_q.delete();
    m_lvl = 0; m_phase = MP_IDLE; m_now = 0; m_step_at = 0; m_close_at = 0;
  endtask

  task automatic model_step(input bit pv, input int pl);
    int   head, stepped, pre_size;
    bit   pop, at_floor, dup, full, add;
    obs_t e;
    m_now++;
    pre_size = m_q.size();
    head     = (pre_size > 0) ? m_q[0] : 0;
    stepped  = m_lvl;
    if (head > m_lvl) stepped = m_lvl + 1;
    if (head < m_lvl) stepped = m_lvl - 1;
    pop      = (m_phase == MP_MOVE) && (m_now == m_step_at) && (pre_size > 0) && (stepped == head);
    at_floor = pv && (pl == m_lvl) && (m_phase != MP_MOVE);
    dup      = 1'b0;
    if (pv && !at_floor)
      foreach (m_q[i]) if (m_q[i] == pl) dup = 1'b1;
    full = pv && !at_floor && !dup && ((pre_size - int'(pop)) == DEPTH);
    add  = pv && !at_floor && !dup && !full;
    case (m_phase)
      MP_IDLE: begin
        if (at_floor) begin
          m_phase = MP_DOOR; m_close_at = m_now + DOOR_CYCLES;
        end else if (pre_size > 0) begin
          m_phase = MP_MOVE; m_step_at = m_now + MOVE_CYCLES;
        end
      end
      MP_MOVE: begin
        if (m_now == m_step_at) begin
          m_lvl = stepped; m_step_at = m_now + MOVE_CYCLES;
          if (pop) begin
            m_phase = MP_DOOR; m_close_at = m_now + DOOR_CYCLES;
          end
        end
      end
      default: begin
        if (at_floor) m_close_at = m_now + DOOR_CYCLES + 1;
        else if (m_now == m_close_at) begin
          if (pre_size > 0) begin
            m_phase = MP_MOVE; m_step_at = m_now + MOVE_CYCLES;
          end else begin
            m_phase = MP_IDLE;
          end
        end
      end
    endcase
    if (pop) void'(m_q.pop_front());
    if (add) m_q.push_back(pl);
    e = '0;
    foreach (m_q[i]) e.queue[i*LVL_W +: LVL_W] = LVL_W'(m_q[i]);
    e.tail      = TAIL_W'(m_q.size());
    e.cur_lvl   = LVL_W'(m_lvl);
    e.moving    = (m_phase == MP_MOVE);
    e.door_open = (m_phase == MP_DOOR);
    e.dropped   = dup || full;
    e.dir_up    = (m_phase == MP_MOVE) && (m_q[0] > m_lvl);
    exp_q.push_back(e);
  endtask

  // Monitor: one scoreboard entry per clock edge, compared mid-cycle.
  always @(negedge clk) begin
    if (rst_n && exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      checks++;
      if (queue !== mon_e.queue || tail !== mon_e.tail || cur_lvl !== mon_e.cur_lvl ||
          moving !== mon_e.moving || door_open !== mon_e.door_open || dropped !== mon_e.dropped ||
          (mon_e.moving && dir_up !== mon_e.dir_up)) begin
        errors++;
        $display("FAIL cycle t=%0t: got q=%h tail=%0d lvl=%0d mv=%b up=%b door=%b drop=%b; want q=%h tail=%0d lvl=%0d mv=%b up=%b door=%b drop=%b",
                 $time, queue, tail, cur_lvl, moving, dir_up, door_open, dropped,
                 mon_e.queue, mon_e.tail, mon_e.cur_lvl, mon_e.moving, mon_e.dir_up,
                 mon_e.door_open, mon_e.dropped);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Drive one press (or none) for the next edge and log the prediction.
  task automatic step(input bit pv, input int pl);
    press_valid = pv;
    press_lvl   = LVL_W'(pl);
    @(posedge clk);
    model_step(pv, pl);
    #1;
    press_valid = 1'b0;
  endtask

  // Assert reset between edges and confirm the clear is immediate.
  task automatic do_reset();
    #5;
    rst_n = 1'b0;
    exp_q.delete();
    model_reset();
    #1;
    chk("rst_queue", int'(queue), 0);
    chk("rst_tail", int'(tail), 0);
    chk("rst_cur_lvl", int'(cur_lvl), 0);
    chk("rst_moving", int'(moving), 0);
    chk("rst_dir_up", int'(dir_up), 0);
    chk("rst_door_open", int'(door_open), 0);
    chk("rst_dropped", int'(dropped), 0);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    do_reset();

    // Idle after reset.
    repeat (50) step(0, 0);

    // Single trip 0 -> 2.
    do_reset();
    step(1, 2);
    chk("trip_queue", int'(queue), 8'h02);
    chk("trip_tail", int'(tail), 1);
    step(0, 0);
    chk("trip_moving", int'(moving), 1);
    repeat (8) step(0, 0);
    chk("trip_lvl1", int'(cur_lvl), 1);
    repeat (8) step(0, 0);
    chk("trip_lvl2", int'(cur_lvl), 2);
    chk("trip_pop_tail", int'(tail), 0);
    chk("trip_door", int'(door_open), 1);
    repeat (15) step(0, 0);
    chk("trip_door_last", int'(door_open), 1);
    step(0, 0);
    chk("trip_door_closed", int'(door_open), 0);

    // Queue order and duplicate rejection.
    do_reset();
    step(1, 1); step(1, 2); step(1, 3);
    chk("order_queue", int'(queue), 8'b00111001);
    chk("order_tail", int'(tail), 3);
    step(1, 2);
    chk("dup_dropped", int'(dropped), 1);
    chk("dup_queue", int'(queue), 8'b00111001);
    step(0, 0);
    chk("dup_pulse_end", int'(dropped), 0);

    // Pop and add on the same edge.
    do_reset();
    step(1, 1); step(1, 2);
    repeat (7) step(0, 0);
    step(1, 3);
    chk("popadd_queue", int'(queue), 8'b00001110);
    chk("popadd_tail", int'(tail), 2);

    // Door hold and re-press.
    do_reset();
    step(1, 0);
    chk("hold_door", int'(door_open), 1);
    chk("hold_tail", int'(tail), 0);
    repeat (9) step(0, 0);
    step(1, 0);
    repeat (DOOR_CYCLES) step(0, 0);
    chk("hold_still_open", int'(door_open), 1);
    step(0, 0);
    chk("hold_closed", int'(door_open), 0);

    // Reset while moving with two pending requests.
    do_reset();
    step(1, 3); step(1, 1);
    repeat (3) step(0, 0);
    chk("midmove_tail", int'(tail), 2);
    chk("midmove_moving", int'(moving), 1);
    do_reset();
    repeat (40) step(0, 0);

    // Randomized traffic with occasional resets.
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 699) == 0) do_reset();
      step($urandom_range(0, 2) == 0, int'($urandom_range(0, 3)));
    end

    #10;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/elevator_queue_ctrl.md
# elevator_queue_ctrl

Sequential controller that owns the elevator request queue and the car's motion/door state. It registers `queue`/`tail` and instantiates `next_queue_add_logic` as its append stage. It feeds that stage the current queue state and commits the result every cycle. It also pops the head entry on arrival and sequences the car through idle, moving and door-open phases.

## Interface
Parameters:
- `LEVELS`, 4: number of floors.
- `LVL_W`, 2: floor code width.
- `DEPTH`, 4: queue slots.
- `TAIL_W`, 3: width of the tail count (0..DEPTH).
- `MOVE_CYCLES`, 8: clock cycles per one-floor step.
- `DOOR_CYCLES`, 16: clock cycles the door stays open.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1: rising-edge clock.
- `rst_n`  in  1: asynchronous active-low reset.
- `press_valid`  in  1: a button press is present this cycle.
- `press_lvl`  in  LVL_W: requested floor.
- `queue`  out  DEPTH*LVL_W: entry i at bits [2i+1:2i]; entry 0 is the head.
- `tail`  out  TAIL_W: count of valid entries, which is also the next free slot.
- `cur_lvl`  out  LVL_W: floor the car is at or last passed.
- `moving`  out  1: car is in motion.
- `dir_up`  out  1: target is above `cur_lvl`; valid only while `moving`.
- `door_open`  out  1: door is open.
- `dropped`  out  1: one-cycle pulse when a press is rejected.

## Operation
- States: IDLE, MOVING, DOOR_OPEN. All outputs are registered.
- Press classification, evaluated against valid entries only (index < tail):
  - If `press_lvl == cur_lvl` and the state is not MOVING, the press is not queued. In IDLE it moves the FSM to DOOR_OPEN. In DOOR_OPEN it reloads the door counter to DOOR_CYCLES.
  - If the level matches any valid entry, the press is rejected as a duplicate and `dropped` pulses.
  - If the post-pop tail equals DEPTH, the press is rejected as full and `dropped` pulses.
  - Otherwise the press is accepted: `next_queue_add_logic` receives `add_new_lvl=1` and writes the level at slot `tail`, and `tail` increments.
- Pop: shift entries down one slot, clear the top slot to 00, decrement `tail`.
- Pop and add in the same cycle: pop first. The post-pop queue and tail feed `next_queue_add_logic`, so the new entry lands at old tail−1. A press is accepted while full if a pop happens in the same cycle.
- IDLE:
  - Go to MOVING when tail > 0.
  - Load the move counter with MOVE_CYCLES−1.
- MOVING:
  - The move counter decrements each cycle.
  - At 0, `cur_lvl` steps ±1 toward the head and the counter reloads.
  - If the new `cur_lvl` equals the head: pop, go to DOOR_OPEN, and load the door counter with DOOR_CYCLES−1.
  - `dir_up` is `head > cur_lvl`.
- DOOR_OPEN:
  - The door counter decrements each cycle.
  - At 0, go to MOVING if tail > 0 (reload the move counter), else go to IDLE.
- Arithmetic:
  - `tail` saturates within 0..DEPTH; it never underflows, and a pop requires tail > 0.
  - `cur_lvl` stays within 0..LEVELS−1.

## Timing
- Reset values: `queue`=0, `tail`=0, `cur_lvl`=0, `moving`=0, `dir_up`=0, `door_open`=0, `dropped`=0, state IDLE, both counters 0.
- Reset asserted mid-operation clears everything immediately. Pending requests are discarded.
- An accepted press at edge k is visible on `queue`/`tail` after edge k.
- Move start: IDLE → MOVING at edge k+1 after the accepting edge k.
- Step cadence: the first floor step occurs at edge k+1+MOVE_CYCLES; later steps follow every MOVE_CYCLES edges.
- On arrival, the pop, `door_open`=1 and `moving`=0 all take effect at the same edge.
- `door_open` stays high for exactly DOOR_CYCLES cycles unless it is reloaded.
- `dropped` is high for exactly the one cycle after the rejected press's edge.

## Structure
- Shared package `elevator_pkg` holds:
  - LEVELS, LVL_W, DEPTH, TAIL_W.
  - The state enum: IDLE, MOVING, DOOR_OPEN.
  - Default MOVE_CYCLES and DOOR_CYCLES.
  - The slot-extract helper for entry i.
- One sub-module: `next_queue_add_logic`, the existing append stage. It is instantiated once, with its inputs taken from the post-pop queue and tail.
- Pop shift, duplicate compare, the FSM and the counters are local to this block.

## Test plan
- Reset and idle: hold `rst_n`=0, then release with no presses. Required: all outputs 0 and state IDLE for 50 cycles.
- Single trip:
  - Stimulus: at `cur_lvl`=0, press 2 at edge 0.
  - After edge 0: `queue`=8'b00000010, `tail`=1.
  - `moving`=1 at edge 1; `cur_lvl`=1 at edge 9; `cur_lvl`=2 at edge 17.
  - At edge 17: `queue`=0, `tail`=0, `door_open`=1.
  - Door closes at edge 33, back to IDLE.
- Queue order and duplicate:
  - Stimulus: at `cur_lvl`=0, press 1, 2, 3 on consecutive cycles, then press 2 again.
  - Required: `queue`=8'b00111001, `tail`=3.
  - The second press of 2 gives a one-cycle `dropped` pulse and leaves the queue unchanged.
- Simultaneous pop and add: with queue [1,2], press 3 on the edge where the car arrives at 1. Required: queue [2,3], i.e. 8'b00001110, with `tail`=2.
- Door hold:
  - In IDLE, press `cur_lvl`. Required: `door_open`=1 next cycle, queue unchanged.
  - Re-press `cur_lvl` 10 cycles into the door-open period. Required: door stays open DOOR_CYCLES cycles from the re-press.
- Reset mid-move: assert `rst_n`=0 while MOVING with tail 2. Required: all outputs return to reset values asynchronously, and no residual pop occurs after release.
